// File: rtl/power_of_five_period_decoder_pkg.sv
// power_of_five_period_decoder_pkg: shared power-of-five tables, window helpers and decoder state type
package power_of_five_period_decoder_pkg;

    localparam int unsigned POW5 [0:7] = '{1, 5, 25, 125, 625, 3125, 15625, 78125};

    localparam int unsigned DEF_MAX_POWER = 7;
    localparam int unsigned DEF_TOL_SHIFT = 3;

    typedef enum logic [1:0] {WAIT_EDGE, MEASURE, DECODE} state_t;

    function automatic int unsigned tol_of(input int k, input int shift);
        return POW5[k] >> shift;
    endfunction

    function automatic int unsigned timeout_of(input int max_power, input int shift);
        return POW5[max_power] + tol_of(max_power, shift);
    endfunction

    function automatic logic in_window(input int unsigned p, input int k, input int shift);
        return (p + tol_of(k, shift) >= POW5[k]) && (p <= POW5[k] + tol_of(k, shift));
    endfunction

    localparam int unsigned TIMEOUT = timeout_of(DEF_MAX_POWER, DEF_TOL_SHIFT);

endpackage

// File: rtl/power_of_five_period_decoder_sync_rise_detect.sv
// sync_rise_detect: two-flop synchroniser followed by a registered rising-edge pulse
module sync_rise_detect (
    input  logic Clock,
    input  logic Reset,
    input  logic SignalIn,
    output logic Rise
);

    logic [1:0] sync;
    logic       last;

    // Resynchronise the input, remember the previous level and pulse once per rising edge
    always_ff @(posedge Clock)
        if (Reset) begin
            sync <= '0;
            last <= 1'b0;
            Rise <= 1'b0;
        end else begin
            sync <= {sync[0], SignalIn};
            last <= sync[1];
            Rise <= sync[1] & ~last;
        end

endmodule

// File: rtl/power_of_five_period_decoder.sv
// power_of_five_period_decoder: measures an input period and decodes it to k where period is 5^k
module power_of_five_period_decoder
    import power_of_five_period_decoder_pkg::*;
#(
    parameter int MAX_POWER  = 7,
    parameter int CNT_W      = 17,
    parameter int TOL_SHIFT  = 3,
    parameter int LOCK_COUNT = 2
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Enable,
    input  logic       SignalIn,
    output logic [2:0] Power,
    output logic       Valid,
    output logic       Locked,
    output logic       NoSignal
);

    localparam int unsigned TMO = timeout_of(MAX_POWER, TOL_SHIFT);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam logic [MW-1:0] LOCK_N = MW'(LOCK_COUNT);

    state_t           state, state_nx;
    logic             rise;
    logic             timeout;
    logic             hit;
    logic [2:0]       k_hit;
    logic [CNT_W-1:0] cnt, p;
    logic [MW-1:0]    mcount, mcount_nx;

    sync_rise_detect u_rise (
        .Clock   (Clock),
        .Reset   (Reset),
        .SignalIn(SignalIn),
        .Rise    (rise)
    );

    assign timeout = cnt > CNT_W'(TMO);

    // Next state: disable forces a fresh start; a rise wins over a timeout in the same cycle
    always_comb begin
        state_nx = state;
        if (!Enable)
            state_nx = WAIT_EDGE;
        else
            unique case (state)
                WAIT_EDGE: state_nx = rise ? MEASURE : WAIT_EDGE;
                MEASURE:   state_nx = rise ? DECODE : timeout ? WAIT_EDGE : MEASURE;
                DECODE:    state_nx = MEASURE;
                default:   state_nx = WAIT_EDGE;
            endcase
    end

    // Compare the captured period against every power window; windows are disjoint so at most one hits
    always_comb begin
        hit = 1'b0;
        k_hit = 3'd0;
        for (int k = 1; k <= MAX_POWER; k++)
            if (in_window(32'(p), k, TOL_SHIFT)) begin
                hit = 1'b1;
                k_hit = 3'(k);
            end
        mcount_nx = (k_hit != Power) ? MW'(1) : (mcount == LOCK_N) ? mcount : mcount + MW'(1);
    end

    // State register
    always_ff @(posedge Clock)
        if (Reset)
            state <= WAIT_EDGE;
        else
            state <= state_nx;

    // Period counter: restarts at 1 after every rise, idles at 0 while waiting, saturates at all-ones
    always_ff @(posedge Clock)
        if (Reset || !Enable || (state == WAIT_EDGE && !rise))
            cnt <= '0;
        else if (rise)
            cnt <= CNT_W'(1);
        else if (cnt != '1)
            cnt <= cnt + CNT_W'(1);

    // Capture, decode results, lock tracking and loss-of-signal flag
    always_ff @(posedge Clock)
        if (Reset) begin
            p        <= '0;
            Power    <= 3'd0;
            Valid    <= 1'b0;
            Locked   <= 1'b0;
            NoSignal <= 1'b0;
            mcount   <= '0;
        end else begin
            Valid <= 1'b0;
            if (!Enable) begin
                Locked   <= 1'b0;
                NoSignal <= 1'b0;
                mcount   <= '0;
            end else if (state == MEASURE && rise) begin
                p <= cnt;
            end else if (state == MEASURE && timeout) begin
                NoSignal <= 1'b1;
                Locked   <= 1'b0;
                mcount   <= '0;
            end else if (state == DECODE) begin
                if (hit) begin
                    Valid    <= 1'b1;
                    Power    <= k_hit;
                    NoSignal <= 1'b0;
                    mcount   <= mcount_nx;
                    Locked   <= mcount_nx == LOCK_N;
                end else begin
                    mcount <= '0;
                    Locked <= 1'b0;
                end
            end
        end

endmodule

// File: tb/tb_power_of_five_period_decoder.sv
// tb_power_of_five_period_decoder: directed edge trains with a queue-based scoreboard on Valid
module tb_power_of_five_period_decoder;

    localparam int TMO = 3515;

    typedef struct packed {
        logic [2:0] pow;
        logic       lock;
    } exp_t;

    typedef struct {
        int per;
        bit v;
        int pow;
        bit lk;
        bit chk;
    } step_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic       SignalIn = 1'b0;
    logic [2:0] Power;
    logic       Valid;
    logic       Locked;
    logic       NoSignal;

    int   tests = 0;
    int   fails = 0;
    int   cyc = 0;
    int   last_rise = 0;
    exp_t sb[$];

    power_of_five_period_decoder #(.MAX_POWER(5)) dut (
        .Clock   (Clock),
        .Reset   (Reset),
        .Enable  (Enable),
        .SignalIn(SignalIn),
        .Power   (Power),
        .Valid   (Valid),
        .Locked  (Locked),
        .NoSignal(NoSignal)
    );

    always #5 Clock = ~Clock;

    always @(posedge Clock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic edge_out(input int per, input bit v, input int pow, input bit lk);
        if (v) sb.push_back('{pow: 3'(pow), lock: lk});
        last_rise = cyc + 1;
        SignalIn = 1'b1;
        repeat (per / 2) @(negedge Clock);
        SignalIn = 1'b0;
        repeat (per - per / 2) @(negedge Clock);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge Clock);
            #1;
            if (Valid) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_valid: got Power %0d with no pending expectation", Power);
                end else begin
                    e = sb.pop_front();
                    chk("valid_power", 32'(Power), 32'(e.pow));
                    chk("valid_locked", 32'(Locked), 32'(e.lock));
                    chk("valid_nosignal", 32'(NoSignal), 0);
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, %0d expectations pending", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        step_t steps[15] = '{
            '{25,   0, 0, 0, 0},
            '{25,   1, 2, 0, 0},
            '{25,   1, 2, 1, 0},
            '{27,   1, 2, 1, 0},
            '{29,   1, 2, 1, 0},
            '{5,    0, 2, 0, 1},
            '{5,    1, 1, 0, 0},
            '{6,    1, 1, 1, 0},
            '{6,    0, 1, 0, 1},
            '{125,  0, 0, 0, 0},
            '{125,  1, 3, 0, 0},
            '{625,  1, 3, 1, 0},
            '{625,  1, 4, 0, 0},
            '{3125, 1, 4, 1, 0},
            '{3125, 1, 5, 0, 0}
        };
        bit seen;
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        @(negedge Clock);
        chk("reset_power", 32'(Power), 0);
        chk("reset_valid", 32'(Valid), 0);
        chk("reset_locked", 32'(Locked), 0);
        chk("reset_nosignal", 32'(NoSignal), 0);
        Enable = 1'b1;
        repeat (4) @(negedge Clock);
        foreach (steps[i]) begin
            edge_out(steps[i].per, steps[i].v, steps[i].pow, steps[i].lk);
            if (steps[i].chk) begin
                chk("reject_power", 32'(Power), 32'(steps[i].pow));
                chk("reject_locked", 32'(Locked), 32'(steps[i].lk));
            end
        end
        edge_out(2, 1, 5, 1);
        seen = 1'b0;
        for (int n = 0; n < TMO + 200 && !seen; n++) begin
            if (NoSignal) seen = 1'b1;
            else @(negedge Clock);
        end
        chk("nosignal_seen", 32'(seen), 1);
        chk("nosignal_latency", 32'(cyc - last_rise), 32'(TMO + 4));
        chk("nosignal_locked", 32'(Locked), 0);
        chk("nosignal_power", 32'(Power), 5);
        repeat (20) @(negedge Clock);
        edge_out(3125, 0, 0, 0);
        chk("nosignal_held", 32'(NoSignal), 1);
        edge_out(3125, 1, 5, 0);
        chk("nosignal_cleared", 32'(NoSignal), 0);
        Reset = 1'b1;
        @(negedge Clock);
        Reset = 1'b0;
        chk("midreset_power", 32'(Power), 0);
        chk("midreset_valid", 32'(Valid), 0);
        chk("midreset_locked", 32'(Locked), 0);
        chk("midreset_nosignal", 32'(NoSignal), 0);
        edge_out(25, 0, 0, 0);
        edge_out(25, 1, 2, 0);
        edge_out(25, 1, 2, 1);
        edge_out(25, 1, 2, 1);
        chk("pre_disable_locked", 32'(Locked), 1);
        Enable = 1'b0;
        edge_out(25, 0, 0, 0);
        chk("disable_power", 32'(Power), 2);
        chk("disable_locked", 32'(Locked), 0);
        chk("disable_nosignal", 32'(NoSignal), 0);
        SignalIn = 1'b1;
        repeat (12) @(negedge Clock);
        SignalIn = 1'b0;
        Enable = 1'b1;
        repeat (13) @(negedge Clock);
        edge_out(25, 0, 0, 0);
        edge_out(25, 1, 2, 0);
        edge_out(25, 1, 2, 1);
        repeat (40) @(negedge Clock);
        chk("scoreboard_drained", 32'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/power_of_five_period_decoder.md
Name: power_of_five_period_decoder

Overview:
Receive-side companion to the team's power-of-five clock dividers. It measures the period of an incoming divided square wave in Clock cycles and decodes it back to the exponent k, where the period is nominally 5^k cycles. It reports Power with a one-cycle Valid strobe, a Locked flag after repeated agreement, and a NoSignal flag on timeout. It sits in the self-test path, downstream of any divider output.

Parameters:
MAX_POWER, 7, highest decodable exponent. Range 1..7.
CNT_W, 17, period counter width. Must hold 5^MAX_POWER + (5^MAX_POWER >> TOL_SHIFT) + 1.
TOL_SHIFT, 3, acceptance window is ±(5^k >> TOL_SHIFT) cycles.
LOCK_COUNT, 2, number of consecutive matching measurements (same k) required to assert Locked. Minimum 1.

Ports:
Clock  input  1  system clock, rising edge
Reset  input  1  synchronous, active-high
Enable  input  1  measurement enable
SignalIn  input  1  divided signal; asynchronous to Clock
Power  output  3  last decoded exponent
Valid  output  1  one-cycle strobe: a new decoded Power is present
Locked  output  1  LOCK_COUNT consecutive identical decodes
NoSignal  output  1  no rising edge within the timeout

Behaviour:
- Reset is synchronous and active-high, on Clock. Reset values: Power=0, Valid=0, Locked=0, NoSignal=0. Both synchroniser flops, the edge register and the counter clear to 0. State goes to WAIT_EDGE.
- Input path: SignalIn passes through a 2-flop synchroniser, then a registered rising-edge detector producing the pulse Rise.
  - Rise asserts 3 cycles after the first Clock edge at which SignalIn is sampled high.
  - Rise pulses are spaced exactly by the input period.
- Period counter:
  - Loads 1 in the cycle after Rise, otherwise increments.
  - Saturates at all-ones.
  - The value captured at a Rise is the period P.
- States:
  - WAIT_EDGE: the counter is idle. On Rise, go to MEASURE.
  - MEASURE: on Rise, capture P and go to DECODE. If the counter exceeds TIMEOUT = 5^MAX_POWER + (5^MAX_POWER >> TOL_SHIFT), set NoSignal=1, clear Locked and the match count, and go to WAIT_EDGE.
  - DECODE: lasts one cycle. Compare P against every k in 1..MAX_POWER in parallel; the match condition is |P − 5^k| <= (5^k >> TOL_SHIFT). Return to MEASURE. A Rise arriving in this cycle starts the next period and is not lost: the counter restarts as for any Rise.
- Valid match in DECODE:
  - Valid=1 for one cycle and Power=k in that same cycle; NoSignal=0.
  - If k equals the previous decode, the match count increments, saturating at LOCK_COUNT. Otherwise the match count is set to 1.
  - Locked=1 when the match count reaches LOCK_COUNT.
- No match in DECODE: Valid=0, Power is held, the match count is cleared, Locked=0.
- k=0 (period 1) is not representable by an edge-measured signal. Power=0 is never decoded; it appears only as the reset value.
- Windows never overlap: the window radius is at most 5^k/8, well below the spacing between adjacent powers. Exactly one k can match.
- Enable=0:
  - State goes to WAIT_EDGE, Locked=0, the match count is cleared, NoSignal=0.
  - Power is held; Valid=0.
  - Re-enabling discards the first partial period.
- A mid-lock period change causes the first new measurement to drop Locked and produce Valid with the new k. Locked reasserts after LOCK_COUNT matches.
- Reset asserted mid-measurement takes priority over everything in that cycle.

Decomposition:
- Shared package:
  - POW5 constant table, indexes 0..7 = 1, 5, 25, 125, 625, 3125, 15625, 78125.
  - Matching tolerance table derived from TOL_SHIFT.
  - State enum {WAIT_EDGE, MEASURE, DECODE}.
  - TIMEOUT constant.
- Sub-module sync_rise_detect: the 2-flop synchroniser plus registered rising-edge pulse. It has no reset-dependent behaviour beyond clearing to 0. It is reused by other capture blocks.

Test Plan:
- Reset, then Enable=1, then a square wave of period 25 → the first Valid at the second measured Rise with Power=2. Locked=1 on the following decode (LOCK_COUNT=2).
- Period 27 → Valid, Power=2. Period 29 → no Valid, Locked drops to 0, Power stays 2.
- Period 5 → Power=1. Period 6 → rejected (tolerance 0 at k=1).
- Locked on period 125, then switch to 625 → the next decode gives Valid, Power=4, Locked=0. Locked=1 on the decode after that.
- SignalIn held low after a lock at 78125 → NoSignal=1 exactly TIMEOUT=87890 counts after the last Rise, with Locked=0. The next two edges at period 78125 → Valid, Power=7, NoSignal=0.
- Reset pulse mid-MEASURE, then Enable deasserted mid-period → all outputs at reset or hold values as specified. No Valid until two fresh Rise pulses after re-enable.
